// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bundle: instruction memory read port plus the decode-facing pair handshake.
// The master side is the fetch queue; the slave side is memory plus decode.
interface fetch_queue_if #(
    parameter int unsigned PC_W = 7
);
    logic [PC_W:0]   imem_addr;
    logic [63:0]     imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     instr_1;
    logic [31:0]     instr_2;
    logic [PC_W-1:0] pc1;
    logic [PC_W-1:0] pc2;
    logic [31:0]     c_stamp;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output instr_1,
        output instr_2,
        output pc1,
        output pc2,
        output c_stamp
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  instr_1,
        input  instr_2,
        input  pc1,
        input  pc2,
        input  c_stamp
    );
endinterface

// File: rtl/fetch_queue.sv
// Dual-wide fetch stage: reads one 8-byte instruction pair per cycle into a small FIFO
// that feeds decode under valid/ready, draining and halting at program end.
module fetch_queue #(
    parameter int unsigned IMEM_BYTES = 128,
    parameter int unsigned PC_W       = 7,
    parameter int unsigned QDEPTH     = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    fetch_queue_if.master      bus,
    output logic [31:0]        cycle_count_o,
    output logic [31:0]        total_instr_count_o,
    output logic               busy_o,
    output logic               done_o
);
    localparam int unsigned AW = $clog2(QDEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [PC_W:0]   pc_q, pc_d;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     count_q;
    logic [31:0]     cyc_q, tot_q;

    logic [63:0]     pair_mem_q  [QDEPTH];
    logic [PC_W-1:0] pc_mem_q    [QDEPTH];
    logic [31:0]     stamp_mem_q [QDEPTH];

    logic            empty, full, pop, push_ok, push, is_zero, last_pair;
    logic [PC_W+1:0] pc_next;
    logic [1:0]      n_nonzero;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(QDEPTH));
    assign pop       = !empty && bus.out_ready;
    // A full queue can still accept when decode frees the head in the same cycle.
    assign push_ok   = (state_q == StFetch) && (!full || pop);
    assign is_zero   = (bus.imem_rdata == 64'd0);
    assign push      = push_ok && !is_zero;
    assign pc_next   = {1'b0, pc_q} + (PC_W+2)'(8);
    assign last_pair = (pc_next >= (PC_W+2)'(IMEM_BYTES));
    assign n_nonzero = {1'b0, |bus.imem_rdata[63:32]} + {1'b0, |bus.imem_rdata[31:0]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StFetch;
            end
            StFetch: begin
                if (push) pc_d = pc_next[PC_W:0];
                if (push_ok && (is_zero || last_pair)) state_d = StDrain;
            end
            StDrain: begin
                if (empty) state_d = StDone;
            end
            StDone: begin
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            pc_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            cyc_q   <= '0;
            tot_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            if (state_q == StFetch || state_q == StDrain) cyc_q <= cyc_q + 32'd1;
            if (push) tot_q <= tot_q + 32'(n_nonzero);
        end
    end

    // Storage needs no reset: stale entries are never visible past the valid mask.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pair_mem_q[wptr_q]  <= bus.imem_rdata;
            pc_mem_q[wptr_q]    <= pc_q[PC_W-1:0];
            stamp_mem_q[wptr_q] <= cyc_q;
        end
    end

    always_comb begin
        bus.imem_addr = (state_q == StFetch) ? pc_q : '0;
        bus.out_valid = !empty;
        bus.instr_1   = '0;
        bus.instr_2   = '0;
        bus.pc1       = '0;
        bus.pc2       = '0;
        bus.c_stamp   = '0;
        if (!empty) begin
            bus.instr_1 = pair_mem_q[rptr_q][63:32];
            bus.instr_2 = pair_mem_q[rptr_q][31:0];
            bus.pc1     = pc_mem_q[rptr_q];
            bus.pc2     = pc_mem_q[rptr_q] + PC_W'(4);
            bus.c_stamp = stamp_mem_q[rptr_q];
        end
    end

    assign cycle_count_o       = cyc_q;
    assign total_instr_count_o = tot_q;
    assign busy_o              = (state_q == StFetch) || (state_q == StDrain);
    assign done_o              = (state_q == StDone);
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a behavioural model predicts each pushed pair into a scoreboard
// queue; every cycle the head and status outputs are compared against it.
module tb_fetch_queue;
    localparam int unsigned PC_W = 7;
    localparam int          QD   = 4;

    typedef enum {MIdle, MFetch, MDrain, MDone} mstate_e;
    typedef struct packed {
        logic [63:0] pair;
        logic [7:0]  pc;
        logic [31:0] stamp;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] cycle_count, total;
    logic        busy, done;
    logic [63:0] mem [16];

    always #5 clk = ~clk;

    fetch_queue_if #(.PC_W(PC_W)) bus ();

    fetch_queue #(
        .IMEM_BYTES(128),
        .PC_W      (PC_W),
        .QDEPTH    (QD)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .start_i            (start),
        .bus                (bus),
        .cycle_count_o      (cycle_count),
        .total_instr_count_o(total),
        .busy_o             (busy),
        .done_o             (done)
    );

    assign bus.imem_rdata = mem[bus.imem_addr[6:3]];

    int          n_err = 0;
    int          n_chk = 0;
    mstate_e     m_state;
    logic [7:0]  m_pc;
    logic [31:0] m_cyc, m_tot;
    int          m_popped;
    logic [7:0]  max_addr;
    ent_t        sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = MIdle;
        m_pc     = '0;
        m_cyc    = '0;
        m_tot    = '0;
        m_popped = 0;
        max_addr = '0;
        sb.delete();
    endtask

    // One cycle: compare at the falling edge, drive inputs, advance the model across the edge.
    task automatic step(input logic rdy, input logic st, input logic rs);
        ent_t        e;
        logic        pop;
        int          occ;
        mstate_e     ns;
        logic [63:0] pair;
        check("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            e = sb[0];
            check("instr_1", 64'(bus.instr_1), 64'(e.pair[63:32]));
            check("instr_2", 64'(bus.instr_2), 64'(e.pair[31:0]));
            check("pc1_pc2", {50'd0, bus.pc1, bus.pc2}, {50'd0, e.pc[6:0], 7'(e.pc + 8'd4)});
            check("c_stamp", 64'(bus.c_stamp), 64'(e.stamp));
        end else begin
            check("instr_idle", {bus.instr_1, bus.instr_2}, 64'd0);
        end
        check("imem_addr", 64'(bus.imem_addr), 64'((m_state == MFetch) ? m_pc : 8'd0));
        check("cycle_count", 64'(cycle_count), 64'(m_cyc));
        check("total_instr", 64'(total), 64'(m_tot));
        check("busy_done", {62'd0, busy, done},
              {62'd0, (m_state == MFetch || m_state == MDrain), (m_state == MDone)});
        if (bus.imem_addr > max_addr) max_addr = bus.imem_addr;

        bus.out_ready = rdy;
        start         = st;
        rst           = rs;

        if (rs) begin
            model_reset();
        end else begin
            occ = sb.size();
            pop = (occ > 0) && rdy;
            ns  = m_state;
            case (m_state)
                MIdle:  if (st) ns = MFetch;
                MFetch: if (occ < QD || pop) begin
                    pair = mem[m_pc[6:3]];
                    if (pair == 64'd0) begin
                        ns = MDrain;
                    end else begin
                        e.pair  = pair;
                        e.pc    = m_pc;
                        e.stamp = m_cyc;
                        sb.push_back(e);
                        m_tot = m_tot + 32'(pair[63:32] != 0) + 32'(pair[31:0] != 0);
                        if (m_pc >= 8'd120) ns = MDrain;
                        m_pc = m_pc + 8'd8;
                    end
                end
                MDrain: if (occ == 0) ns = MDone;
                default: ;
            endcase
            if (pop) begin
                void'(sb.pop_front());
                m_popped++;
            end
            if (m_state == MFetch || m_state == MDrain) m_cyc = m_cyc + 32'd1;
            m_state = ns;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
    endtask

    function automatic logic ready_pat(input int pat, input int i);
        if (pat == 0) return 1'b1;
        if (i < 8)    return 1'b0;
        if (i == 8)   return 1'b1;
        if (i < 12)   return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_to_done(input int budget, input int pat);
        int i = 0;
        while (m_state != MDone && i < budget) begin
            step(ready_pat(pat, i), 1'b0, 1'b0);
            i++;
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic fill_mem(input int n_pairs);
        for (int i = 0; i < 16; i++)
            mem[i] = (i < n_pairs) ? {32'h1000_0000 + 32'(2*i + 1), 32'h2000_0000 + 32'(2*i + 2)}
                                   : 64'd0;
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        bus.out_ready = 1'b0;
        fill_mem(5);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        // Five pairs then a zero pair, decode always ready.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        run_to_done(60, 0);
        check("s1_pairs", 64'(m_popped), 64'd5);
        check("s1_total", 64'(total), 64'd10);

        // Full memory: fetch stops on the address bound.
        fill_mem(16);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        run_to_done(80, 0);
        check("s2_max_addr", 64'(max_addr), 64'd120);
        check("s2_total", 64'(total), 64'd32);

        // Back-pressure, a single-cycle pop while full, and a half-zero pair.
        fill_mem(16);
        mem[3][31:0] = 32'd0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        run_to_done(100, 1);
        check("s3_total", 64'(total), 64'd31);
        check("s3_pairs", 64'(m_popped), 64'd16);

        // Reset with three pairs queued, then a clean restart.
        fill_mem(16);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("s4_queued", 64'(bus.out_valid), 64'd1);
        step(1'b0, 1'b0, 1'b1);
        check("s4_rst_valid", 64'(bus.out_valid), 64'd0);
        check("s4_rst_count", {cycle_count, total}, 64'd0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("s4_restart_pc1", 64'(bus.pc1), 64'd0);
        run_to_done(80, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
